// File: rtl/multi_countdown_timer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
//   Shared types and helpers for the multi-channel BCD countdown timer.
//   - cmd_e      : command encoding on the command bus
//   - state_e    : per-channel timer state
//   - bcd_hms_t  : packed BCD hh:mm:ss count
//   - MAX_MIN_BCD, bcd_hms_valid() : range check applied to LOAD data
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD   = 2'b00,
        CMD_START  = 2'b01,
        CMD_PAUSE  = 2'b10,
        CMD_RELOAD = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_RINGING = 2'b11
    } state_e;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_hms_t;

    localparam logic [7:0] MAX_MIN_BCD = 8'h59;

    // Every nibble must be a decimal digit and minutes/seconds must not exceed 59.
    function automatic logic bcd_hms_valid(input bcd_hms_t t);
        return (t.hh[7:4] <= 4'd9) && (t.hh[3:0] <= 4'd9) &&
               (t.mm <= MAX_MIN_BCD) && (t.mm[3:0] <= 4'd9) &&
               (t.ss <= MAX_MIN_BCD) && (t.ss[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/multi_countdown_timer_if.sv
// -----------------------------------------------------------------------------
// multi_countdown_timer_if
//   Command bus from the key/command decoder to the countdown timer.
//   cmd_valid         one-cycle command strobe
//   cmd[1:0]          00 LOAD, 01 START, 10 PAUSE, 11 RELOAD
//   cmd_ch[CH_W-1:0]  target channel
//   hour_in/minute_in/second_in  BCD load value (LOAD only)
//   cmd_err           one-cycle reject pulse, returned by the timer
//   Modports: master (command source), slave (timer).
// -----------------------------------------------------------------------------
interface multi_countdown_timer_if #(
    parameter int CH_W = 2
);
    logic            cmd_valid;
    logic [1:0]      cmd;
    logic [CH_W-1:0] cmd_ch;
    logic [7:0]      hour_in;
    logic [7:0]      minute_in;
    logic [7:0]      second_in;
    logic            cmd_err;

    modport master (
        output cmd_valid, cmd, cmd_ch, hour_in, minute_in, second_in,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid, cmd, cmd_ch, hour_in, minute_in, second_in,
        output cmd_err
    );
endinterface

// File: rtl/multi_countdown_timer_bcd_hms_dec.sv
// -----------------------------------------------------------------------------
// bcd_hms_dec
//   Combinational BCD hh:mm:ss minus one with borrow ss -> mm -> hh.
//   val_i      BCD count in
//   dec_o      val_i - 1 second (val_i unchanged when it is already zero)
//   is_zero_o  val_i == 00:00:00
// -----------------------------------------------------------------------------
module bcd_hms_dec
    import countdown_pkg::*;
(
    input  bcd_hms_t val_i,
    output bcd_hms_t dec_o,
    output logic     is_zero_o
);

    // Decrement a two-digit BCD field; wrap_val is the field value after a borrow.
    function automatic logic [7:0] bcd_dec8(input logic [7:0] v, input logic [7:0] wrap_val);
        logic [7:0] r;
        if (v[3:0] != 4'd0) begin
            r = {v[7:4], v[3:0] - 4'd1};
        end else if (v[7:4] != 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = wrap_val;
        end
        return r;
    endfunction

    logic ss_borrow;
    logic mm_borrow;

    always_comb begin
        ss_borrow = (val_i.ss == 8'h00);
        mm_borrow = ss_borrow && (val_i.mm == 8'h00);
        is_zero_o = mm_borrow && (val_i.hh == 8'h00);
        dec_o     = val_i;
        if (!is_zero_o) begin
            dec_o.ss = bcd_dec8(val_i.ss, MAX_MIN_BCD);
            if (ss_borrow) begin
                dec_o.mm = bcd_dec8(val_i.mm, MAX_MIN_BCD);
            end
            // hh is never zero here when a borrow reaches it, so no wrap occurs.
            if (mm_borrow) begin
                dec_o.hh = bcd_dec8(val_i.hh, 8'h00);
            end
        end
    end

endmodule

// File: rtl/multi_countdown_timer.sv
// -----------------------------------------------------------------------------
// multi_countdown_timer
//   NUM_CH independent BCD hh:mm:ss countdown timers sharing a 1 Hz tick.
//   Each channel keeps a count, a load backup, a run state and a ring flag.
//
//   Parameters: NUM_CH (1..16), CH_W (channel index width), RING_TICKS (1..255)
//   Ports:
//     clk, rst_n (async, active-low)
//     tick_1hz                  one-clk 1 Hz enable
//     cmd_bus (slave modport)   command bus, returns cmd_err pulse
//     rd_ch                     channel shown on hour/minute/second_out
//     hour_out/minute_out/second_out  registered BCD readout (0 if rd_ch out of range)
//     running[NUM_CH], ring[NUM_CH], ring_any
//
//   Build option: define COUNTDOWN_AUTO_RELOAD_EN to make an expiring channel reload
//   its backup and keep running, with ring pulsing for one tick period. A zero backup
//   still expires into RINGING.
// -----------------------------------------------------------------------------
module multi_countdown_timer
    import countdown_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int RING_TICKS = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_1hz,
    multi_countdown_timer_if.slave cmd_bus,
    input  logic [CH_W-1:0]       rd_ch,
    output logic [7:0]            hour_out,
    output logic [7:0]            minute_out,
    output logic [7:0]            second_out,
    output logic [NUM_CH-1:0]     running,
    output logic [NUM_CH-1:0]     ring,
    output logic                  ring_any
);

    bcd_hms_t          count_q   [NUM_CH];
    bcd_hms_t          backup_q  [NUM_CH];
    state_e            state_q   [NUM_CH];
    logic [7:0]        ring_cnt_q[NUM_CH];
    logic [NUM_CH-1:0] running_q;
    logic [NUM_CH-1:0] ring_q;
    logic              cmd_err_q;
    bcd_hms_t          rd_q;

    bcd_hms_t          dec_d     [NUM_CH];
    logic [NUM_CH-1:0] zero_d;
    logic [NUM_CH-1:0] cmd_hit;
    logic              cmd_err_d;
    bcd_hms_t          rd_d;
    bcd_hms_t          load_val;
    logic              load_ok;
    cmd_e              cmd_op;

    assign cmd_op   = cmd_e'(cmd_bus.cmd);
    assign load_val = {cmd_bus.hour_in, cmd_bus.minute_in, cmd_bus.second_in};
    assign load_ok  = bcd_hms_valid(load_val);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // A command addressed to this channel also masks its tick this cycle.
        assign cmd_hit[g] = cmd_bus.cmd_valid && (cmd_bus.cmd_ch == CH_W'(g));

        bcd_hms_dec u_dec (
            .val_i     (count_q[g]),
            .dec_o     (dec_d[g]),
            .is_zero_o (zero_d[g])
        );
    end

    always_comb begin
        cmd_err_d = 1'b0;
        if (cmd_bus.cmd_valid) begin
            if (cmd_hit == '0) begin
                cmd_err_d = 1'b1;               // channel index beyond NUM_CH
            end else if ((cmd_op == CMD_LOAD) && !load_ok) begin
                cmd_err_d = 1'b1;
            end else if (cmd_op == CMD_START) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cmd_hit[i] && zero_d[i] &&
                        ((state_q[i] == ST_IDLE) || (state_q[i] == ST_PAUSED))) begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_d = count_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]    <= '0;
                backup_q[i]   <= '0;
                state_q[i]    <= ST_IDLE;
                ring_cnt_q[i] <= '0;
            end
            running_q <= '0;
            ring_q    <= '0;
            cmd_err_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            cmd_err_q <= cmd_err_d;
            rd_q      <= rd_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmd_hit[i]) begin
                    unique case (cmd_op)
                        CMD_LOAD: begin
                            if (load_ok) begin
                                count_q[i]    <= load_val;
                                backup_q[i]   <= load_val;
                                state_q[i]    <= ST_IDLE;
                                running_q[i]  <= 1'b0;
                                ring_q[i]     <= 1'b0;
                                ring_cnt_q[i] <= '0;
                            end
                        end
                        CMD_START: begin
                            case (state_q[i])
                                ST_IDLE, ST_PAUSED: begin
                                    if (!zero_d[i]) begin
                                        state_q[i]   <= ST_RUN;
                                        running_q[i] <= 1'b1;
                                    end
                                end
                                ST_RINGING: begin
                                    state_q[i]    <= ST_IDLE;
                                    ring_q[i]     <= 1'b0;
                                    ring_cnt_q[i] <= '0;
                                end
                                default: ;
                            endcase
                        end
                        CMD_PAUSE: begin
                            case (state_q[i])
                                ST_RUN: begin
                                    state_q[i]   <= ST_PAUSED;
                                    running_q[i] <= 1'b0;
                                    ring_q[i]    <= 1'b0;
                                end
                                ST_RINGING: begin
                                    state_q[i]    <= ST_IDLE;
                                    ring_q[i]     <= 1'b0;
                                    ring_cnt_q[i] <= '0;
                                end
                                default: ;
                            endcase
                        end
                        CMD_RELOAD: begin
                            count_q[i]    <= backup_q[i];
                            state_q[i]    <= ST_IDLE;
                            running_q[i]  <= 1'b0;
                            ring_q[i]     <= 1'b0;
                            ring_cnt_q[i] <= '0;
                        end
                    endcase
                end else if (tick_1hz) begin
                    case (state_q[i])
                        ST_RUN: begin
                            if (dec_d[i] == '0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                if (backup_q[i] != '0) begin
                                    count_q[i] <= backup_q[i];
                                    ring_q[i]  <= 1'b1;
                                end else begin
                                    count_q[i]    <= '0;
                                    state_q[i]    <= ST_RINGING;
                                    running_q[i]  <= 1'b0;
                                    ring_q[i]     <= 1'b1;
                                    ring_cnt_q[i] <= '0;
                                end
`else
                                count_q[i]    <= '0;
                                state_q[i]    <= ST_RINGING;
                                running_q[i]  <= 1'b0;
                                ring_q[i]     <= 1'b1;
                                ring_cnt_q[i] <= '0;
`endif
                            end else begin
                                count_q[i] <= dec_d[i];
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                ring_q[i]  <= 1'b0;   // reload pulse lasts one tick period
`endif
                            end
                        end
                        ST_RINGING: begin
                            if (ring_cnt_q[i] == 8'(RING_TICKS - 1)) begin
                                state_q[i]    <= ST_IDLE;
                                ring_q[i]     <= 1'b0;
                                ring_cnt_q[i] <= '0;
                            end else begin
                                ring_cnt_q[i] <= ring_cnt_q[i] + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign hour_out        = rd_q.hh;
    assign minute_out      = rd_q.mm;
    assign second_out      = rd_q.ss;
    assign running         = running_q;
    assign ring            = ring_q;
    assign ring_any        = |ring_q;
    assign cmd_bus.cmd_err = cmd_err_q;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_countdown_timer
//   Directed scenarios followed by randomized commands/ticks. A seconds-based
//   reference model predicts every output; a compare process checks it each cycle.
//   NUM_CH=5 with CH_W=3 so out-of-range channel indices can be exercised.
// -----------------------------------------------------------------------------
module tb_multi_countdown_timer;

    localparam int NUM_CH     = 5;
    localparam int CH_W       = 3;
    localparam int RING_TICKS = 30;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_RING = 3;
    localparam logic [1:0] C_LOAD = 2'b00, C_START = 2'b01, C_PAUSE = 2'b10, C_RELOAD = 2'b11;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              tick_1hz = 1'b0;
    logic [CH_W-1:0]   rd_ch    = '0;
    logic [7:0]        hour_out, minute_out, second_out;
    logic [NUM_CH-1:0] running, ring;
    logic              ring_any;

    multi_countdown_timer_if #(.CH_W(CH_W)) cif ();

    multi_countdown_timer #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .RING_TICKS (RING_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .cmd_bus    (cif),
        .rd_ch      (rd_ch),
        .hour_out   (hour_out),
        .minute_out (minute_out),
        .second_out (second_out),
        .running    (running),
        .ring       (ring),
        .ring_any   (ring_any)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (counts kept as plain seconds) ----------------
    int         m_secs[NUM_CH];
    int         m_bak [NUM_CH];
    int         m_st  [NUM_CH];
    int         m_rc  [NUM_CH];
    logic [23:0] m_out = '0;
    logic        m_err = 1'b0;

    function automatic bit bcd_ok(input logic [7:0] b, input int max_hi);
        return (int'(b[7:4]) <= max_hi) && (int'(b[3:0]) <= 9);
    endfunction

    function automatic int to_secs(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (int'(h[7:4]) * 10 + int'(h[3:0])) * 3600 +
               (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 +
               (int'(s[7:4]) * 10 + int'(s[3:0]));
    endfunction

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_secs[c] = 0; m_bak[c] = 0; m_st[c] = S_IDLE; m_rc[c] = 0;
        end
        m_out = '0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        int r, tgt;
        r     = int'(rd_ch);
        tgt   = int'(cif.cmd_ch);
        m_out = (r < NUM_CH) ? to_bcd(m_secs[r]) : 24'h0;
        m_err = 1'b0;
        if (cif.cmd_valid && tgt >= NUM_CH) m_err = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cif.cmd_valid && tgt == c) begin
                case (cif.cmd)
                    C_LOAD: begin
                        if (bcd_ok(cif.hour_in, 9) && bcd_ok(cif.minute_in, 5) && bcd_ok(cif.second_in, 5)) begin
                            m_secs[c] = to_secs(cif.hour_in, cif.minute_in, cif.second_in);
                            m_bak[c]  = m_secs[c];
                            m_st[c]   = S_IDLE;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    C_START: begin
                        if (m_st[c] == S_IDLE || m_st[c] == S_PAUSED) begin
                            if (m_secs[c] == 0) m_err = 1'b1;
                            else m_st[c] = S_RUN;
                        end else if (m_st[c] == S_RING) begin
                            m_st[c] = S_IDLE;
                        end
                    end
                    C_PAUSE: begin
                        if (m_st[c] == S_RUN) m_st[c] = S_PAUSED;
                        else if (m_st[c] == S_RING) m_st[c] = S_IDLE;
                    end
                    default: begin
                        m_secs[c] = m_bak[c];
                        m_st[c]   = S_IDLE;
                    end
                endcase
            end else if (tick_1hz) begin
                if (m_st[c] == S_RUN) begin
                    m_secs[c] = m_secs[c] - 1;
                    if (m_secs[c] == 0) begin
                        m_st[c] = S_RING;
                        m_rc[c] = 0;
                    end
                end else if (m_st[c] == S_RING) begin
                    m_rc[c] = m_rc[c] + 1;
                    if (m_rc[c] >= RING_TICKS) m_st[c] = S_IDLE;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NUM_CH-1:0] er, eg;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                er[c] = (m_st[c] == S_RUN);
                eg[c] = (m_st[c] == S_RING);
            end
            check("hour_out",   32'(hour_out),    32'(m_out[23:16]));
            check("minute_out", 32'(minute_out),  32'(m_out[15:8]));
            check("second_out", 32'(second_out),  32'(m_out[7:0]));
            check("running",    32'(running),     32'(er));
            check("ring",       32'(ring),        32'(eg));
            check("ring_any",   32'(ring_any),    32'(|eg));
            check("cmd_err",    32'(cif.cmd_err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rd_now();
        return 32'({hour_out, minute_out, second_out});
    endfunction

    task automatic do_cmd(input logic [1:0] c, input int ch,
                          input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cif.cmd_valid = 1'b1;
        cif.cmd       = c;
        cif.cmd_ch    = CH_W'(ch);
        cif.hour_in   = h;
        cif.minute_in = m;
        cif.second_in = s;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
    endtask

    // Tick then one idle cycle, so the readout already reflects the new count.
    task automatic do_tick();
        tick_1hz = 1'b1;
        @(posedge clk); #1;
        tick_1hz = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd       = 2'b00;
        cif.cmd_ch    = '0;
        cif.hour_in   = 8'h00;
        cif.minute_in = 8'h00;
        cif.second_in = 8'h00;
        rst_n         = 1'b0;
        idle(3);
        check("rst_out",     rd_now(),              32'h0);
        check("rst_running", 32'(running),          32'h0);
        check("rst_ring",    32'(ring),             32'h0);
        check("rst_err",     32'(cif.cmd_err),      32'h0);
        rst_n = 1'b1;
        idle(2);

        // 00:01:00 counts down through the minute borrow
        do_cmd(C_LOAD, 0, 8'h00, 8'h01, 8'h00);
        do_cmd(C_START, 0, 8'h00, 8'h00, 8'h00);
        rd_ch = 3'd0;
        do_tick();
        check("t1_first",  rd_now(), 32'h000059);
        do_tick();
        check("t1_second", rd_now(), 32'h000058);
        check("t1_run0",   32'(running[0]), 32'h1);

        // Expiry rings, then auto-stops after RING_TICKS ticks
        do_cmd(C_LOAD, 1, 8'h00, 8'h00, 8'h02);
        do_cmd(C_START, 1, 8'h00, 8'h00, 8'h00);
        do_tick();
        do_tick();
        check("t2_ring1",    32'(ring[1]),    32'h1);
        check("t2_ring_any", 32'(ring_any),   32'h1);
        check("t2_run1",     32'(running[1]), 32'h0);
        repeat (RING_TICKS - 1) do_tick();
        check("t2_ring_hold", 32'(ring[1]), 32'h1);
        do_tick();
        check("t2_ring_off",  32'(ring[1]), 32'h0);

        // Hour borrow, then pause holds the count
        do_cmd(C_LOAD, 2, 8'h01, 8'h00, 8'h00);
        do_cmd(C_START, 2, 8'h00, 8'h00, 8'h00);
        rd_ch = 3'd2;
        do_tick();
        check("t3_hour_borrow", rd_now(), 32'h005959);
        do_cmd(C_PAUSE, 2, 8'h00, 8'h00, 8'h00);
        repeat (3) do_tick();
        check("t3_paused", rd_now(), 32'h005959);
        check("t3_run2",   32'(running[2]), 32'h0);

        // Rejected commands
        do_cmd(C_LOAD, 2, 8'h00, 8'h60, 8'h00);
        check("t4_bad_load_err", 32'(cif.cmd_err), 32'h1);
        idle(1);
        check("t4_err_pulse", 32'(cif.cmd_err), 32'h0);
        check("t4_unchanged", rd_now(), 32'h005959);
        do_cmd(C_START, 3, 8'h00, 8'h00, 8'h00);
        check("t4_start_zero", 32'(cif.cmd_err), 32'h1);
        do_cmd(C_START, 6, 8'h00, 8'h00, 8'h00);
        check("t4_bad_ch", 32'(cif.cmd_err), 32'h1);
        rd_ch = 3'd6;
        idle(1);
        check("t4_bad_rd", rd_now(), 32'h0);

        // Command and tick collide on ch0 only
        do_cmd(C_LOAD, 0, 8'h00, 8'h00, 8'h10);
        do_cmd(C_START, 0, 8'h00, 8'h00, 8'h00);
        do_cmd(C_LOAD, 3, 8'h00, 8'h00, 8'h05);
        do_cmd(C_START, 3, 8'h00, 8'h00, 8'h00);
        cif.cmd_valid = 1'b1;
        cif.cmd       = C_PAUSE;
        cif.cmd_ch    = 3'd0;
        tick_1hz      = 1'b1;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        tick_1hz      = 1'b0;
        rd_ch = 3'd0;
        idle(1);
        check("t5_ch0_held", rd_now(), 32'h000010);
        check("t5_ch0_paused", 32'(running[0]), 32'h0);
        rd_ch = 3'd3;
        idle(1);
        check("t5_ch3_dec", rd_now(), 32'h000004);
        check("t5_ch3_run", 32'(running[3]), 32'h1);

        // Asynchronous reset mid-count
        do_cmd(C_START, 0, 8'h00, 8'h00, 8'h00);
        rd_ch = 3'd0;
        do_tick();
        rst_n = 1'b0;
        #1;
        check("t6_out",     rd_now(),         32'h0);
        check("t6_running", 32'(running),     32'h0);
        check("t6_ring",    32'(ring),        32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        check("t6_no_retain", rd_now(), 32'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            cif.cmd_valid = ($urandom_range(0, 3) == 0);
            cif.cmd       = 2'($urandom_range(0, 3));
            cif.cmd_ch    = CH_W'($urandom_range(0, 5));
            if ($urandom_range(0, 7) != 0) begin
                cif.hour_in   = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
                cif.minute_in = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
                cif.second_in = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            end else begin
                cif.hour_in   = 8'($urandom_range(0, 255));
                cif.minute_in = 8'($urandom_range(0, 255));
                cif.second_in = 8'($urandom_range(0, 255));
            end
            tick_1hz = ($urandom_range(0, 2) == 0);
            rd_ch    = CH_W'($urandom_range(0, 6));
            @(posedge clk); #1;
        end
        cif.cmd_valid = 1'b0;
        tick_1hz      = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
